// File: rtl/acc_ctrl.sv
// acc_ctrl: register-mapped launch/monitor controller for a single-operation accelerator.
//
// Ports
//   i_clk, i_reset        : clock and synchronous active-high reset
//   i_wr_en, i_rd_en      : bus-side write / read strobes (one access per cycle)
//   i_addr, i_wdata       : byte offset (bits 1:0 ignored) and write data
//   o_rdata               : registered read data, 1-cycle latency, held when idle
//   o_acc_start           : one-cycle launch pulse
//   o_acc_op_a/_b, o_acc_mode : operands and mode, driven from OPA / OPB / CTRL[7:4]
//   i_acc_done, i_acc_result  : completion pulse and result from the accelerator
//   o_irq                 : level interrupt, IRQ_EN & (DONE | TIMEOUT)
//
// Register map (word offsets): 0x00 CTRL, 0x04 STATUS, 0x08 OPA, 0x0C OPB,
// 0x10 RESULT (RO), 0x14 TLIMIT[15:0]; all other offsets read 0.
module acc_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wr_en,
   input  logic        i_rd_en,
   input  logic [7:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_acc_start,
   output logic [31:0] o_acc_op_a,
   output logic [31:0] o_acc_op_b,
   output logic [3:0]  o_acc_mode,
   input  logic        i_acc_done,
   input  logic [31:0] i_acc_result,
   output logic        o_irq
);

   localparam logic [5:0] AddrCtrl   = 6'h00;
   localparam logic [5:0] AddrStatus = 6'h01;
   localparam logic [5:0] AddrOpa    = 6'h02;
   localparam logic [5:0] AddrOpb    = 6'h03;
   localparam logic [5:0] AddrResult = 6'h04;
   localparam logic [5:0] AddrTlimit = 6'h05;

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StComplete} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_tlimit;
   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic [31:0] r_result;
   logic [31:0] r_rdata;
   logic [3:0]  r_mode;
   logic        r_irq_en;
   logic        r_done;
   logic        r_timeout;
   logic        r_acc_start;

   logic [5:0]  w_sel;
   logic        w_busy;
   logic        w_cfg_wr;
   logic        w_start;
   logic        w_done_hit;
   logic        w_timeout_hit;
   logic [31:0] w_rd_data;
   logic        w_unused;

   assign w_unused = ^i_addr[1:0];

   always_comb begin
      w_sel      = i_addr[7:2];
      w_busy     = (r_state != StIdle);
      // Configuration writes are locked out for the whole job.
      w_cfg_wr   = i_wr_en && !w_busy;
      w_start    = w_cfg_wr && (w_sel == AddrCtrl) && i_wdata[0];
      w_done_hit = (r_state == StWait) && i_acc_done;
      // Counter counts completed WAIT cycles; done in the same cycle takes priority.
      w_timeout_hit = (r_state == StWait) && !i_acc_done && (r_tlimit != 16'd0) &&
                      (r_cnt == r_tlimit - 16'd1);
   end

   always_comb begin
      w_rd_data = 32'd0;
      case (w_sel)
         AddrCtrl:   w_rd_data = {24'd0, r_mode, 2'b00, r_irq_en, 1'b0};
         AddrStatus: w_rd_data = {29'd0, r_timeout, r_done, w_busy};
         AddrOpa:    w_rd_data = r_opa;
         AddrOpb:    w_rd_data = r_opb;
         AddrResult: w_rd_data = r_result;
         AddrTlimit: w_rd_data = {16'd0, r_tlimit};
         default:    w_rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_cnt       <= 16'd0;
         r_tlimit    <= 16'h0100;
         r_opa       <= 32'd0;
         r_opb       <= 32'd0;
         r_result    <= 32'd0;
         r_rdata     <= 32'd0;
         r_mode      <= 4'd0;
         r_irq_en    <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_acc_start <= 1'b0;
      end else begin
         r_acc_start <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_state     <= StLaunch;
                  r_acc_start <= 1'b1;
               end
            end
            StLaunch: begin
               r_state <= StWait;
               r_cnt   <= 16'd0;
            end
            StWait: begin
               r_cnt <= r_cnt + 16'd1;
               if (w_done_hit) begin
                  r_state  <= StComplete;
                  r_result <= i_acc_result;
               end else if (w_timeout_hit) begin
                  r_state <= StIdle;
               end
            end
            StComplete: r_state <= StIdle;
            default:    r_state <= StIdle;
         endcase

         if (w_cfg_wr) begin
            case (w_sel)
               AddrCtrl: begin
                  r_irq_en <= i_wdata[1];
                  r_mode   <= i_wdata[7:4];
               end
               AddrOpa:    r_opa    <= i_wdata;
               AddrOpb:    r_opb    <= i_wdata;
               AddrTlimit: r_tlimit <= i_wdata[15:0];
               default:    ;
            endcase
         end

         // W1C first, hardware set afterwards so a coincident set wins.
         if (i_wr_en && (w_sel == AddrStatus)) begin
            if (i_wdata[1]) r_done    <= 1'b0;
            if (i_wdata[2]) r_timeout <= 1'b0;
         end
         if (w_done_hit)    r_done    <= 1'b1;
         if (w_timeout_hit) r_timeout <= 1'b1;

         if (i_rd_en) r_rdata <= w_rd_data;
      end
   end

   assign o_rdata     = r_rdata;
   assign o_acc_start = r_acc_start;
   assign o_acc_op_a  = r_opa;
   assign o_acc_op_b  = r_opb;
   assign o_acc_mode  = r_mode;
   assign o_irq       = r_irq_en & (r_done | r_timeout);

endmodule

// File: doc/acc_ctrl.md
ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL: reset, input, 1, synchronous and active-high; sampled only on the rising edge of clk.
REQ-003 SHALL: wr_en, input, 1, register write strobe from the bus-side bridge, one write per cycle.
REQ-004 SHALL: rd_en, input, 1, register read strobe from the bus-side bridge.
REQ-005 SHALL: addr, input, 8, byte offset; bits 1:0 ignored.
REQ-006 SHALL: wdata, input, 32, write data, valid in the same cycle as wr_en.
REQ-007 SHALL: rdata, output, 32, registered read data.
REQ-008 SHALL: acc_start, output, 1, one-cycle launch pulse to the accelerator.
REQ-009 SHALL: acc_op_a / acc_op_b, output, 32 each, operand registers driven straight from OPA / OPB.
REQ-010 SHALL: acc_mode, output, 4, operation select, driven from CTRL[7:4].
REQ-011 SHALL: acc_done, input, 1, completion pulse from the accelerator.
REQ-012 SHALL: acc_result, input, 32, accelerator result, valid while acc_done=1.
REQ-013 SHALL: irq, output, 1, level interrupt.

Function
REQ-014 SHALL: register map:
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN, bits 7:4 MODE.
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE, bit2 TIMEOUT; bits 1 and 2 are W1C.
- 0x08 OPA; 0x0C OPB.
- 0x10 RESULT (RO).
- 0x14 TLIMIT, bits 15:0.
REQ-015 SHALL: rdata is updated on the clock edge following rd_en (1-cycle latency) and holds its value when rd_en=0.
REQ-016 SHALL: reads of unmapped offsets return 0; writes to unmapped or RO offsets have no effect.
REQ-017 SHALL: the FSM has four states: IDLE, LAUNCH, WAIT, COMPLETE.
REQ-018 SHALL: IDLE -> LAUNCH on a write to CTRL with wdata[0]=1; MODE and IRQ_EN from that same write take effect.
REQ-019 SHALL: acc_start = 1 only in LAUNCH, for exactly one cycle; LAUNCH -> WAIT unconditionally, clearing the timeout counter.
REQ-020 SHALL: in WAIT the 16-bit counter increments every cycle; if acc_done=1, go to COMPLETE, latch acc_result into RESULT, set DONE.
REQ-021 SHALL: in WAIT, if TLIMIT != 0 and counter == TLIMIT-1 with acc_done=0, set TIMEOUT and go to IDLE; RESULT is unchanged.
REQ-022 SHALL: TLIMIT = 0 disables the timeout, so WAIT persists until acc_done.
REQ-023 SHALL: acc_done and the timeout condition in the same cycle resolve as done.
REQ-024 SHALL: COMPLETE -> IDLE unconditionally after one cycle.
REQ-025 SHALL: BUSY = 1 in LAUNCH, WAIT and COMPLETE.
REQ-026 SHALL: while BUSY, writes to CTRL, OPA, OPB and TLIMIT are ignored, including START.
REQ-027 SHALL: while BUSY, STATUS W1C writes are still honoured.
REQ-028 SHALL: acc_done in IDLE or LAUNCH is ignored (no state or flag change).
REQ-029 SHALL: if a hardware set of DONE/TIMEOUT and a W1C of the same bit occur in the same cycle, the set wins.
REQ-030 SHALL: a START accepted from IDLE clears neither DONE nor TIMEOUT; software clears them.
REQ-031 SHALL: irq = IRQ_EN & (DONE | TIMEOUT), combinational from registered state.

Reset
REQ-032 SHALL: on reset:
- FSM = IDLE; counter = 0.
- CTRL, OPA, OPB, RESULT, DONE, TIMEOUT = 0.
- TLIMIT = 0x0100.
- rdata = 0; acc_start = 0; irq = 0.
REQ-033 SHALL: reset asserted mid-operation (any non-IDLE state) returns to IDLE on that edge, with no further acc_start and no RESULT update.

Verification
REQ-034 SHALL: write OPA=5, OPB=7, then CTRL=0x0000_0013 -> acc_start is high exactly one cycle later, for one cycle, with acc_mode=1, acc_op_a=5, acc_op_b=7; acc_done with acc_result=12 after 3 cycles -> RESULT=12, STATUS=0x2, irq=1; W1C 0x2 to STATUS -> irq=0.
REQ-035 SHALL: TLIMIT=4, START, acc_done never asserted -> TIMEOUT set exactly 4 cycles after entering WAIT, BUSY=0, RESULT unchanged.
REQ-036 SHALL: TLIMIT=4, acc_done asserted on the 4th WAIT cycle -> DONE=1, TIMEOUT=0.
REQ-037 SHALL: while BUSY, write OPA=0xFFFF and START -> OPA keeps its old value and no second acc_start occurs; W1C of STATUS still clears a stale DONE.
REQ-038 SHALL: assert reset during WAIT -> next cycle STATUS=0, TLIMIT=0x0100; a later acc_done causes no change.
